// File: rtl/activation_pwq.sv
// activation_pwq: pipelined piecewise-quadratic activation (sigmoid / tanh)
// for the LSTM gate datapath. Four register stages with a single global
// advance enable; a stalled output freezes the whole pipe.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready = pipeline advance)
//   in_data                 x, signed, FRAC_W fraction bits
//   in_mode                 0 = sigmoid(x), 1 = tanh(x)
//   in_tag                  sideband tag, carried unmodified with its beat
//   out_valid/out_ready     output handshake
//   out_data                f(x), signed, OUT_FRAC fraction bits
//   out_tag                 tag of the beat in out_data
//   out_sat                 beat hit a saturated region or the output clamp
//   busy                    any stage (incl. output register) holds a beat
module activation_pwq #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 7,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_FRAC  = 7,
  parameter int unsigned COEF_FRAC = 12,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_sat,
  output logic                     busy
);

  // Internal widths: every product is kept at full precision.
  localparam int unsigned COEF_W   = COEF_FRAC + 2;
  localparam int unsigned P1_W     = COEF_W + DATA_W;
  localparam int unsigned SQ_W     = 2 * DATA_W;
  localparam int unsigned P2_W     = COEF_W + SQ_W;
  localparam int unsigned ACC_W    = P2_W + 3;
  localparam int unsigned ACC_FRAC = COEF_FRAC + 2 * FRAC_W;
  localparam int          SH       = int'(ACC_FRAC) - int'(OUT_FRAC);

  if (OUT_FRAC > COEF_FRAC + 2 * FRAC_W) begin : g_cfg_err
    $error("activation_pwq: OUT_FRAC larger than internal fraction width");
  end

  // Coefficient table is authored at 12 fraction bits; rescale to COEF_FRAC.
  function automatic logic signed [COEF_W-1:0] coef(input int v);
    if (COEF_FRAC >= 12) return COEF_W'(v <<< (COEF_FRAC - 12));
    else                 return COEF_W'(v >>> (12 - COEF_FRAC));
  endfunction

  localparam logic signed [COEF_W-1:0] A_C0 = coef(832);
  localparam logic signed [COEF_W-1:0] A_C1 = coef(294);
  localparam logic signed [COEF_W-1:0] A_C2 = coef(26);
  localparam logic signed [COEF_W-1:0] B_C0 = coef(2056);
  localparam logic signed [COEF_W-1:0] B_C1 = coef(1117);
  localparam logic signed [COEF_W-1:0] B_C2 = coef(166);
  localparam logic signed [COEF_W-1:0] C_C0 = coef(2040);
  localparam logic signed [COEF_W-1:0] C_C1 = coef(1117);
  localparam logic signed [COEF_W-1:0] C_C2 = coef(-166);
  localparam logic signed [COEF_W-1:0] D_C0 = coef(3264);
  localparam logic signed [COEF_W-1:0] D_C1 = coef(294);
  localparam logic signed [COEF_W-1:0] D_C2 = coef(-26);
  localparam logic signed [COEF_W-1:0] ONE_C0 = coef(4096);

  localparam logic signed [DATA_W-1:0] X_T3   = DATA_W'(3 <<< FRAC_W);
  localparam logic signed [DATA_W-1:0] X_T6   = DATA_W'(6 <<< FRAC_W);
  localparam logic signed [DATA_W-1:0] X_ZERO = '0;
  localparam logic signed [DATA_W-1:0] X_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] X_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1) <<< ACC_FRAC;
  localparam logic signed [ACC_W-1:0] ACC_RND  = (SH > 0) ? (ACC_W'(1) <<< (SH - 1)) : '0;
  localparam logic signed [ACC_W-1:0] OUT_HI   = ACC_W'(1) <<< OUT_FRAC;
  localparam logic signed [ACC_W-1:0] OUT_LO_T = -OUT_HI;
  localparam logic signed [ACC_W-1:0] OUT_LO_S = '0;

  // Stage valids and pipeline advance
  logic s1_v_q, s2_v_q, s3_v_q, out_v_q, busy_q;
  logic s1_v_d, s2_v_d, s3_v_d, out_v_d, busy_d;
  logic adv_c;

  assign adv_c     = !out_v_q || out_ready;
  assign in_ready  = adv_c;
  assign out_valid = out_v_q;
  assign busy      = busy_q;

  // Next-state for valids; busy tracks the next-state OR so it matches the stages
  always_comb begin
    s1_v_d  = s1_v_q;
    s2_v_d  = s2_v_q;
    s3_v_d  = s3_v_q;
    out_v_d = out_v_q;
    if (adv_c) begin
      s1_v_d  = in_valid;
      s2_v_d  = s1_v_q;
      s3_v_d  = s2_v_q;
      out_v_d = s3_v_q;
    end
    busy_d = s1_v_d | s2_v_d | s3_v_d | out_v_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s3_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s3_v_q  <= s3_v_d;
      out_v_q <= out_v_d;
      busy_q  <= busy_d;
    end
  end

  // S1: argument scaling (tanh uses 2x, saturated) and segment/coefficient select
  logic signed [DATA_W-1:0] xp_c;
  logic signed [COEF_W-1:0] c0_c, c1_c, c2_c;
  logic                     rsat_c;

  always_comb begin
    xp_c = in_data;
    if (in_mode) begin
      if (in_data[DATA_W-1] != in_data[DATA_W-2]) xp_c = in_data[DATA_W-1] ? X_MIN : X_MAX;
      else                                        xp_c = in_data <<< 1;
    end
    c0_c   = '0;
    c1_c   = '0;
    c2_c   = '0;
    rsat_c = 1'b0;
    if (xp_c <= -X_T6) begin
      rsat_c = 1'b1;
    end else if (xp_c <= -X_T3) begin
      c0_c = A_C0; c1_c = A_C1; c2_c = A_C2;
    end else if (xp_c <= X_ZERO) begin
      c0_c = B_C0; c1_c = B_C1; c2_c = B_C2;
    end else if (xp_c <= X_T3) begin
      c0_c = C_C0; c1_c = C_C1; c2_c = C_C2;
    end else if (xp_c <= X_T6) begin
      c0_c = D_C0; c1_c = D_C1; c2_c = D_C2;
    end else begin
      c0_c   = ONE_C0;
      rsat_c = 1'b1;
    end
  end

  logic signed [DATA_W-1:0] s1_x_q;
  logic signed [COEF_W-1:0] s1_c0_q, s1_c1_q, s1_c2_q;
  logic                     s1_mode_q, s1_rsat_q;
  logic [TAG_W-1:0]         s1_tag_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_x_q    <= '0;
      s1_c0_q   <= '0;
      s1_c1_q   <= '0;
      s1_c2_q   <= '0;
      s1_mode_q <= 1'b0;
      s1_rsat_q <= 1'b0;
      s1_tag_q  <= '0;
    end else if (adv_c && in_valid) begin
      s1_x_q    <= xp_c;
      s1_c0_q   <= c0_c;
      s1_c1_q   <= c1_c;
      s1_c2_q   <= c2_c;
      s1_mode_q <= in_mode;
      s1_rsat_q <= rsat_c;
      s1_tag_q  <= in_tag;
    end
  end

  // S2: linear term and square
  logic signed [P1_W-1:0] p1_c;
  logic signed [SQ_W-1:0] sq_c;

  assign p1_c = P1_W'(s1_c1_q) * P1_W'(s1_x_q);
  assign sq_c = SQ_W'(s1_x_q) * SQ_W'(s1_x_q);

  logic signed [P1_W-1:0]   s2_p1_q;
  logic signed [SQ_W-1:0]   s2_sq_q;
  logic signed [COEF_W-1:0] s2_c0_q, s2_c2_q;
  logic                     s2_mode_q, s2_rsat_q;
  logic [TAG_W-1:0]         s2_tag_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_p1_q   <= '0;
      s2_sq_q   <= '0;
      s2_c0_q   <= '0;
      s2_c2_q   <= '0;
      s2_mode_q <= 1'b0;
      s2_rsat_q <= 1'b0;
      s2_tag_q  <= '0;
    end else if (adv_c && s1_v_q) begin
      s2_p1_q   <= p1_c;
      s2_sq_q   <= sq_c;
      s2_c0_q   <= s1_c0_q;
      s2_c2_q   <= s1_c2_q;
      s2_mode_q <= s1_mode_q;
      s2_rsat_q <= s1_rsat_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  // S3: quadratic term
  logic signed [P2_W-1:0] p2_c;

  assign p2_c = P2_W'(s2_c2_q) * P2_W'(s2_sq_q);

  logic signed [P2_W-1:0]   s3_p2_q;
  logic signed [P1_W-1:0]   s3_p1_q;
  logic signed [COEF_W-1:0] s3_c0_q;
  logic                     s3_mode_q, s3_rsat_q;
  logic [TAG_W-1:0]         s3_tag_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s3_p2_q   <= '0;
      s3_p1_q   <= '0;
      s3_c0_q   <= '0;
      s3_mode_q <= 1'b0;
      s3_rsat_q <= 1'b0;
      s3_tag_q  <= '0;
    end else if (adv_c && s2_v_q) begin
      s3_p2_q   <= p2_c;
      s3_p1_q   <= s2_p1_q;
      s3_c0_q   <= s2_c0_q;
      s3_mode_q <= s2_mode_q;
      s3_rsat_q <= s2_rsat_q;
      s3_tag_q  <= s2_tag_q;
    end
  end

  // S4: align terms to ACC_FRAC, tanh = 2*sigma(2x)-1, round half-up, clamp
  logic signed [ACC_W-1:0] acc_c, rnd_c, res_c, lo_c;
  logic                    clamp_c;

  always_comb begin
    acc_c = (ACC_W'(s3_c0_q) <<< (2 * FRAC_W))
          + (ACC_W'(s3_p1_q) <<< FRAC_W)
          + ACC_W'(s3_p2_q);
    if (s3_mode_q) acc_c = (acc_c <<< 1) - ACC_ONE;
    rnd_c   = (acc_c + ACC_RND) >>> SH;
    lo_c    = s3_mode_q ? OUT_LO_T : OUT_LO_S;
    res_c   = rnd_c;
    clamp_c = 1'b0;
    if (rnd_c > OUT_HI) begin
      res_c   = OUT_HI;
      clamp_c = 1'b1;
    end else if (rnd_c < lo_c) begin
      res_c   = lo_c;
      clamp_c = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_tag  <= '0;
      out_sat  <= 1'b0;
    end else if (adv_c && s3_v_q) begin
      out_data <= OUT_W'(res_c);
      out_tag  <= s3_tag_q;
      out_sat  <= clamp_c | s3_rsat_q;
    end
  end

endmodule
